// File: rtl/cnt_chain_hi_seg_if.sv
// Layer-boundary bundle for one upper counter segment: carry/mode/load inputs
// and the count, carry and wrap-phase status driven back across the TSV.
interface cnt_chain_hi_seg_if #(
    parameter int WIDTH = 8,
    parameter int PH_W  = 3
);
    logic                 cin_IN;
    logic [1:0]           mode_IN;
    logic [WIDTH-1:0]     load_val_IN;
    logic [WIDTH-1:0]     cnt_OUT;
    logic                 cout_OUT;
    logic                 zero_OUT;
    logic                 wrap_strb_OUT;
    logic [PH_W-1:0]      phase_OUT;
    logic [2**PH_W-1:0]   phase_dec_OUT;
    logic                 ovf_OUT;

    modport master (
        output cin_IN, mode_IN, load_val_IN,
        input  cnt_OUT, cout_OUT, zero_OUT, wrap_strb_OUT,
               phase_OUT, phase_dec_OUT, ovf_OUT
    );

    modport slave (
        input  cin_IN, mode_IN, load_val_IN,
        output cnt_OUT, cout_OUT, zero_OUT, wrap_strb_OUT,
               phase_OUT, phase_dec_OUT, ovf_OUT
    );
endinterface

// File: rtl/cnt_chain_hi_seg.sv
// Upper segment of the cascaded event counter: extends the lower slice by WIDTH
// bits and tracks how many times it has wrapped in a small phase counter.
module cnt_chain_hi_seg #(
    parameter int WIDTH = 8,
    parameter int PH_W  = 3
) (
    input  logic             clk1_IN,
    input  logic             rst_IN,
    cnt_chain_hi_seg_if.slave seg
);
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    localparam int NDEC = 2**PH_W;

    mode_e             mode;
    logic              cout;
    logic [WIDTH-1:0]  cnt_q,   cnt_d;
    logic              zero_q,  zero_d;
    logic              wrap_q,  wrap_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [NDEC-1:0]   dec_q,   dec_d;
    logic              ovf_q,   ovf_d;

    assign mode = mode_e'(seg.mode_IN);

    // No register on the carry path, so a whole chain ripples within one cycle.
    assign cout = (mode == MODE_COUNT) && seg.cin_IN && (cnt_q == '1);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        cnt_d   = cnt_q;
        phase_d = phase_q;
        ovf_d   = ovf_q;
        wrap_d  = cout;

        case (mode)
            MODE_CLEAR: begin
                cnt_d   = '0;
                phase_d = '0;
                ovf_d   = 1'b0;
            end
            MODE_LOAD:  cnt_d = seg.load_val_IN;
            MODE_COUNT: if (seg.cin_IN) cnt_d = cnt_q + WIDTH'(1);
            default:    ;
        endcase

        if (cout) begin
            if (phase_q == '1) ovf_d = 1'b1;
            phase_d = phase_q + PH_W'(1);
        end

        // Status flags decode the next state so they line up with cnt/phase.
        zero_d         = (cnt_d == '0);
        dec_d          = '0;
        dec_d[phase_d] = 1'b1;
    end

    always_ff @(posedge clk1_IN or posedge rst_IN) begin
        if (rst_IN) begin
            cnt_q   <= '0;
            zero_q  <= 1'b1;
            wrap_q  <= 1'b0;
            phase_q <= '0;
            dec_q   <= NDEC'(1);
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            wrap_q  <= wrap_d;
            phase_q <= phase_d;
            dec_q   <= dec_d;
            ovf_q   <= ovf_d;
        end
    end

    assign seg.cnt_OUT       = cnt_q;
    assign seg.cout_OUT      = cout;
    assign seg.zero_OUT      = zero_q;
    assign seg.wrap_strb_OUT = wrap_q;
    assign seg.phase_OUT     = phase_q;
    assign seg.phase_dec_OUT = dec_q;
    assign seg.ovf_OUT       = ovf_q;
endmodule

// File: tb/tb_cnt_chain_hi_seg.sv
// Directed bench for cnt_chain_hi_seg: a reference model queues the expected
// post-edge state for every driven step, which is popped and compared after the edge.
module tb_cnt_chain_hi_seg;
    localparam int WIDTH = 8;
    localparam int PH_W  = 3;
    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_COUNT = 2'b01;
    localparam logic [1:0] M_LOAD  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    typedef struct packed {
        logic [7:0] cnt;
        logic       zero;
        logic       wrap;
        logic [2:0] phase;
        logic [7:0] dec;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic cin_tb;
    logic cascade_en;

    int n_total = 0;
    int n_pass  = 0;

    exp_t sb_q[$];
    logic [7:0] m_cnt;
    logic [2:0] m_phase;
    logic       m_ovf;

    cnt_chain_hi_seg_if #(.WIDTH(WIDTH), .PH_W(PH_W)) main_if ();
    cnt_chain_hi_seg_if #(.WIDTH(WIDTH), .PH_W(PH_W)) lo_if ();

    assign main_if.cin_IN = cascade_en ? lo_if.cout_OUT : cin_tb;

    always #5 clk = ~clk;

    cnt_chain_hi_seg #(.WIDTH(WIDTH), .PH_W(PH_W)) u_dut (
        .clk1_IN (clk),
        .rst_IN  (rst),
        .seg     (main_if)
    );

    cnt_chain_hi_seg #(.WIDTH(WIDTH), .PH_W(PH_W)) u_lo (
        .clk1_IN (clk),
        .rst_IN  (rst),
        .seg     (lo_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            n_total++;
            assert (!$isunknown(main_if.mode_IN)) n_pass++;
            else $error("FAIL mode_known: observed %b expected known", main_if.mode_IN);
        end
    end

    task automatic model_reset();
        m_cnt   = 8'h00;
        m_phase = 3'd0;
        m_ovf   = 1'b0;
    endtask

    // One clock of stimulus: drive on the falling edge, check the carry
    // combinationally, queue the model's prediction, compare after the edge.
    task automatic step(input logic [1:0] mode, input logic cin, input logic [7:0] lv);
        exp_t e;
        exp_t got;
        logic exp_cout;
        @(negedge clk);
        main_if.mode_IN     = mode;
        cin_tb              = cin;
        main_if.load_val_IN = lv;
        #1;
        exp_cout = (mode == M_COUNT) && cin && (m_cnt == 8'hFF);
        check("cout", 32'(main_if.cout_OUT), 32'(exp_cout));
        case (mode)
            M_CLEAR: begin m_cnt = 8'h00; m_phase = 3'd0; m_ovf = 1'b0; end
            M_LOAD:  m_cnt = lv;
            M_COUNT: if (cin) m_cnt = m_cnt + 8'd1;
            default: ;
        endcase
        if (exp_cout) begin
            if (m_phase == 3'd7) m_ovf = 1'b1;
            m_phase = m_phase + 3'd1;
        end
        e.cnt   = m_cnt;
        e.zero  = (m_cnt == 8'h00);
        e.wrap  = exp_cout;
        e.phase = m_phase;
        e.dec   = 8'h01 << m_phase;
        e.ovf   = m_ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL sb_underflow: observed empty queue expected one entry");
        end else begin
            got = sb_q.pop_front();
            check("sb_cnt",   32'(main_if.cnt_OUT),       32'(got.cnt));
            check("sb_zero",  32'(main_if.zero_OUT),      32'(got.zero));
            check("sb_wrap",  32'(main_if.wrap_strb_OUT), 32'(got.wrap));
            check("sb_phase", 32'(main_if.phase_OUT),     32'(got.phase));
            check("sb_dec",   32'(main_if.phase_dec_OUT), 32'(got.dec));
            check("sb_ovf",   32'(main_if.ovf_OUT),       32'(got.ovf));
        end
    endtask

    initial begin
        rst                 = 1'b1;
        cin_tb              = 1'b0;
        cascade_en          = 1'b0;
        main_if.mode_IN     = M_HOLD;
        main_if.load_val_IN = 8'h00;
        lo_if.cin_IN        = 1'b0;
        lo_if.mode_IN       = M_HOLD;
        lo_if.load_val_IN   = 8'h00;
        model_reset();
        #12;
        check("rst_cnt",  32'(main_if.cnt_OUT),       32'h00);
        check("rst_zero", 32'(main_if.zero_OUT),      32'h1);
        check("rst_dec",  32'(main_if.phase_dec_OUT), 32'h01);
        check("rst_cout", 32'(main_if.cout_OUT),      32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Count three, then hold with cin low.
        repeat (3) step(M_COUNT, 1'b1, 8'h00);
        check("count_3", 32'(main_if.cnt_OUT), 32'h03);
        repeat (2) step(M_COUNT, 1'b0, 8'h00);
        check("hold_3", 32'(main_if.cnt_OUT), 32'h03);
        step(M_HOLD, 1'b1, 8'hAA);
        check("hold_mode", 32'(main_if.cnt_OUT), 32'h03);

        // Single wrap from 0xFE.
        step(M_LOAD, 1'b0, 8'hFE);
        step(M_COUNT, 1'b1, 8'h00);
        check("wrap_ff", 32'(main_if.cnt_OUT), 32'hFF);
        step(M_COUNT, 1'b1, 8'h00);
        check("wrap_cnt",   32'(main_if.cnt_OUT),       32'h00);
        check("wrap_zero",  32'(main_if.zero_OUT),      32'h1);
        check("wrap_phase", 32'(main_if.phase_OUT),     32'h1);
        check("wrap_strb",  32'(main_if.wrap_strb_OUT), 32'h1);
        check("wrap_dec",   32'(main_if.phase_dec_OUT), 32'h02);
        step(M_HOLD, 1'b0, 8'h00);
        check("wrap_strb_off", 32'(main_if.wrap_strb_OUT), 32'h0);

        // Clear, then eight wraps drive phase round to 0 and set ovf.
        step(M_CLEAR, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(M_LOAD, 1'b0, 8'hFF);
            step(M_COUNT, 1'b1, 8'h00);
        end
        check("ovf_phase", 32'(main_if.phase_OUT), 32'h0);
        check("ovf_set",   32'(main_if.ovf_OUT),   32'h1);
        step(M_LOAD, 1'b0, 8'h33);
        check("ovf_load_keep", 32'(main_if.ovf_OUT), 32'h1);
        step(M_CLEAR, 1'b0, 8'h00);
        check("ovf_clear", 32'(main_if.ovf_OUT), 32'h0);
        check("clr_cnt",   32'(main_if.cnt_OUT), 32'h00);

        // Priority: clear beats a pending carry, load beats count.
        step(M_LOAD, 1'b0, 8'hFF);
        step(M_CLEAR, 1'b1, 8'h00);
        check("pri_clr_cnt",   32'(main_if.cnt_OUT),   32'h00);
        check("pri_clr_phase", 32'(main_if.phase_OUT), 32'h0);
        step(M_LOAD, 1'b0, 8'h44);
        step(M_LOAD, 1'b1, 8'h00);
        check("pri_load_cnt", 32'(main_if.cnt_OUT), 32'h00);

        // Rebuild ovf, then hit reset mid-cycle with cnt=0x5A.
        for (int i = 0; i < 8; i++) begin
            step(M_LOAD, 1'b0, 8'hFF);
            step(M_COUNT, 1'b1, 8'h00);
        end
        step(M_LOAD, 1'b0, 8'h5A);
        check("pre_rst_cnt", 32'(main_if.cnt_OUT), 32'h5A);
        check("pre_rst_ovf", 32'(main_if.ovf_OUT), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt",  32'(main_if.cnt_OUT),       32'h00);
        check("arst_zero", 32'(main_if.zero_OUT),      32'h1);
        check("arst_dec",  32'(main_if.phase_dec_OUT), 32'h01);
        check("arst_ovf",  32'(main_if.ovf_OUT),       32'h0);
        main_if.mode_IN = M_HOLD;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Two-segment cascade: upper increments on the edge the lower wraps.
        @(negedge clk);
        lo_if.mode_IN       = M_LOAD;
        lo_if.load_val_IN   = 8'hFF;
        main_if.mode_IN     = M_LOAD;
        main_if.load_val_IN = 8'h10;
        @(negedge clk);
        lo_if.mode_IN   = M_COUNT;
        lo_if.cin_IN    = 1'b1;
        main_if.mode_IN = M_COUNT;
        cascade_en      = 1'b1;
        #1;
        check("casc_lo_cout", 32'(lo_if.cout_OUT),   32'h1);
        check("casc_hi_pre",  32'(main_if.cnt_OUT),  32'h10);
        @(posedge clk);
        #1;
        check("casc_lo_cnt",  32'(lo_if.cnt_OUT),    32'h00);
        check("casc_lo_zero", 32'(lo_if.zero_OUT),   32'h1);
        check("casc_hi_cnt",  32'(main_if.cnt_OUT),  32'h11);
        @(negedge clk);
        lo_if.mode_IN   = M_HOLD;
        lo_if.cin_IN    = 1'b0;
        main_if.mode_IN = M_HOLD;
        cascade_en      = 1'b0;
        step(M_CLEAR, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
